// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the instruction memory.
// Accepts a byte stream (valid/ready), packs MSB-first bytes into 32-bit
// instructions, writes them from BASE_ADDR upward and keeps the CPU held
// until the complete image is in place.
// Optional build macro: IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_en_imem_o,
    output logic [31:0] addr_imem_o,
    output logic [31:0] wr_instr_imem_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CSUM_EN
    // Where the stream goes once the last word (or an empty header) is consumed.
    localparam state_t END_STATE_C = S_CSUM;

    // Running checksum step: XOR-fold one more byte into the accumulator.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`else
    localparam state_t END_STATE_C = S_DONE;
`endif

    state_t      state_r;
    state_t      next_state_s;
    logic        hs_s;
    logic        start_take_s;
    logic [15:0] hdr_cnt_s;
    logic [7:0]  cnt_hi_r;
    logic [15:0] cnt_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_idx_r;
    logic [23:0] asm_r;
    logic        ready_r;
    logic        wr_en_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic        hold_r;
    logic        done_r;
    logic        err_r;
    logic        ready_next_s;
    logic        wr_en_next_s;
    logic        hold_next_s;
    logic        done_next_s;
    logic        err_next_s;
    logic [31:0] addr_next_s;
    logic [31:0] data_next_s;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_r;
`endif

    assign hs_s         = byte_valid_i & ready_r;
    assign hdr_cnt_s    = {cnt_hi_r, byte_data_i};
    assign start_take_s = start_i & ((state_r == S_DONE) | (state_r == S_ERR));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_HDR0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: header parsing, word assembly, write slot, terminal states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_HDR0: begin
                if (hs_s) next_state_s = S_HDR1;
                else      next_state_s = state_r;
            end
            S_HDR1: begin
                if (!hs_s)                                   next_state_s = state_r;
                else if (hdr_cnt_s == 16'd0)                 next_state_s = END_STATE_C;
                else if ({1'b0, hdr_cnt_s} > MAX_WORDS_C)    next_state_s = S_ERR;
                else                                         next_state_s = S_DATA;
            end
            S_DATA: begin
                if (hs_s && (byte_idx_r == 2'd3)) next_state_s = S_WRITE;
                else                              next_state_s = state_r;
            end
            S_WRITE: begin
                if ((word_idx_r + 16'd1) == cnt_r) next_state_s = END_STATE_C;
                else                               next_state_s = S_DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (!hs_s)                       next_state_s = state_r;
                else if (byte_data_i == csum_r)  next_state_s = S_DONE;
                else                             next_state_s = S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start_i) next_state_s = S_HDR0;
                else         next_state_s = state_r;
            end
            default: next_state_s = S_HDR0;
        endcase
    end

    // Output decode: next-cycle values of every registered output.
    always_comb begin
        ready_next_s = 1'b0;
        case (next_state_s)
            S_HDR0, S_HDR1, S_DATA: ready_next_s = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM:                 ready_next_s = 1'b1;
`endif
            default:                ready_next_s = 1'b0;
        endcase
        wr_en_next_s = (next_state_s == S_WRITE);
        done_next_s  = (next_state_s == S_DONE);
        err_next_s   = (next_state_s == S_ERR);
        hold_next_s  = (next_state_s != S_DONE);
        addr_next_s  = addr_r;
        data_next_s  = data_r;
        if (next_state_s == S_WRITE) begin
            addr_next_s = BASE_ADDR + {14'd0, word_idx_r, 2'b00};
            data_next_s = {asm_r, byte_data_i};
        end else if (start_take_s) begin
            addr_next_s = BASE_ADDR;
            data_next_s = data_r;
        end else begin
            addr_next_s = addr_r;
            data_next_s = data_r;
        end
    end

    // Output registers so every port is driven straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b0;
            wr_en_r <= 1'b0;
            addr_r  <= BASE_ADDR;
            data_r  <= 32'h0000_0000;
            hold_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            wr_en_r <= wr_en_next_s;
            addr_r  <= addr_next_s;
            data_r  <= data_next_s;
            hold_r  <= hold_next_s;
            done_r  <= done_next_s;
            err_r   <= err_next_s;
        end
    end

    // Header capture, word/byte indices and the partial-word shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_hi_r   <= 8'h00;
            cnt_r      <= 16'd0;
            word_idx_r <= 16'd0;
            byte_idx_r <= 2'd0;
            asm_r      <= 24'h00_0000;
        end else begin
            case (state_r)
                S_HDR0: if (hs_s) cnt_hi_r <= byte_data_i;
                S_HDR1: if (hs_s) begin
                    cnt_r      <= hdr_cnt_s;
                    word_idx_r <= 16'd0;
                    byte_idx_r <= 2'd0;
                end
                S_DATA: if (hs_s) begin
                    asm_r      <= {asm_r[15:0], byte_data_i};
                    byte_idx_r <= byte_idx_r + 2'd1;
                end
                S_WRITE: word_idx_r <= word_idx_r + 16'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum accumulator: seeded by the first header byte, folds header and data bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else if (hs_s && (state_r == S_HDR0)) begin
            csum_r <= byte_data_i;
        end else if (hs_s && ((state_r == S_HDR1) || (state_r == S_DATA))) begin
            csum_r <= csum_fold(csum_r, byte_data_i);
        end
    end
`endif

    assign byte_ready_o    = ready_r;
    assign wr_en_imem_o    = wr_en_r;
    assign addr_imem_o     = addr_r;
    assign wr_instr_imem_o = data_r;
    assign cpu_hold_o      = hold_r;
    assign done_o          = done_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte streams against a stream-level model.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        wr_en_imem_o;
    logic [31:0] addr_imem_o;
    logic [31:0] wr_instr_imem_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] cap_addr_q[$];
    logic [31:0] cap_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_done;
    logic        exp_err;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .wr_en_imem_o(wr_en_imem_o),
        .addr_imem_o(addr_imem_o), .wr_instr_imem_o(wr_instr_imem_o),
        .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Write monitor: records every imem write strobe mid-cycle.
    always @(negedge clk) begin
        if (wr_en_imem_o === 1'b1) begin
            cap_addr_q.push_back(addr_imem_o);
            cap_data_q.push_back(wr_instr_imem_o);
        end
    end

    // Reference model: expected writes and final status from the stream contents.
    task automatic model_stream();
        int cnt;
        logic [7:0] x;
        exp_addr_q.delete();
        exp_data_q.delete();
        cnt = int'({stim_q[0], stim_q[1]});
        if (cnt > MAXW) begin
            exp_err = 1'b1;
            exp_done = 1'b0;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            exp_addr_q.push_back(BASE + 32'(4 * w));
            exp_data_q.push_back({stim_q[2+4*w], stim_q[3+4*w], stim_q[4+4*w], stim_q[5+4*w]});
        end
`ifdef IMEM_LOADER_CSUM_EN
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * cnt; i++) x = x ^ stim_q[i];
        exp_done = (stim_q[2+4*cnt] == x);
        exp_err  = !exp_done;
`else
        x = 8'h00;
        exp_done = 1'b1;
        exp_err  = 1'b0;
`endif
    endtask

    task automatic make_stream(input int nwords, input bit good_csum);
        logic [7:0] x;
        stim_q.delete();
        stim_q.push_back(8'(nwords >> 8));
        stim_q.push_back(8'(nwords));
        for (int i = 0; i < 4 * nwords; i++) stim_q.push_back(8'($urandom));
        x = 8'h00;
        foreach (stim_q[i]) x = x ^ stim_q[i];
`ifdef IMEM_LOADER_CSUM_EN
        stim_q.push_back(good_csum ? x : (x ^ 8'h01));
`else
        if (!good_csum) x = 8'h00;
`endif
    endtask

    task automatic send_bytes(input int first, input int last, input int gap_pct);
        for (int i = first; i < last; i++) begin
            int budget;
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                byte_valid_i = 1'b0;
                byte_data_i = 8'($urandom);
                @(negedge clk);
            end
            byte_valid_i = 1'b1;
            byte_data_i = stim_q[i];
            budget = 0;
            while (byte_ready_o !== 1'b1 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 50) begin
                tests_run++;
                tests_failed++;
                $display("FAIL handshake_timeout byte %0d: ready=%b required 1", i, byte_ready_o);
                byte_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int budget = 0;
        while (done_o !== 1'b1 && err_o !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        tests_run++;
        if (budget >= 100) begin
            tests_failed++;
            $display("FAIL %s_end_timeout: done=%b err=%b required one of them 1", name, done_o, err_o);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        tests_run++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || cpu_hold_o !== 1'b1 ||
            addr_imem_o !== BASE || byte_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rearm: done=%b err=%b hold=%b addr=%h ready=%b required 0 0 1 %h 1",
                     done_o, err_o, cpu_hold_o, addr_imem_o, byte_ready_o, BASE);
        end
    endtask

    task automatic check_load(input string name);
        tests_run++;
        if (cap_addr_q.size() != exp_addr_q.size()) begin
            tests_failed++;
            $display("FAIL %s_count: writes=%0d required %0d", name, cap_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                tests_run++;
                if (cap_addr_q[i] !== exp_addr_q[i] || cap_data_q[i] !== exp_data_q[i]) begin
                    tests_failed++;
                    $display("FAIL %s_write%0d: %h@%h required %h@%h", name, i,
                             cap_data_q[i], cap_addr_q[i], exp_data_q[i], exp_addr_q[i]);
                end
            end
        end
        tests_run++;
        if (done_o !== exp_done || err_o !== exp_err || cpu_hold_o !== !exp_done) begin
            tests_failed++;
            $display("FAIL %s_status: done=%b err=%b hold=%b required %b %b %b", name,
                     done_o, err_o, cpu_hold_o, exp_done, exp_err, !exp_done);
        end
        if (exp_addr_q.size() > 0) begin
            tests_run++;
            if (addr_imem_o !== exp_addr_q[$] || wr_instr_imem_o !== exp_data_q[$] || wr_en_imem_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_hold: %h@%h wr_en=%b required %h@%h 0", name,
                         wr_instr_imem_o, addr_imem_o, wr_en_imem_o, exp_data_q[$], exp_addr_q[$]);
            end
        end
    endtask

    // Complete load of the current stim_q (or a fresh random one) with optional gaps.
    task automatic run_load(input string name, input int nwords, input bit fresh, input int gap_pct);
        if (done_o === 1'b1 || err_o === 1'b1) pulse_start();
        cap_addr_q.delete();
        cap_data_q.delete();
        if (fresh) make_stream(nwords, 1'b1);
        model_stream();
        send_bytes(0, stim_q.size(), gap_pct);
        wait_end(name);
        check_load(name);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (byte_ready_o !== 1'b0 || wr_en_imem_o !== 1'b0 || addr_imem_o !== BASE ||
            wr_instr_imem_o !== 32'h0 || cpu_hold_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: ready=%b wr=%b addr=%h data=%h hold=%b done=%b err=%b required 0 0 %h 0 1 0 0",
                     byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_hold_o, done_o, err_o, BASE);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b hold=%b required 1 1", byte_ready_o, cpu_hold_o);
        end
    endtask

    task automatic test_vector();
        logic [7:0] x;
        stim_q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        x = 8'h00;
        foreach (stim_q[i]) x = x ^ stim_q[i];
`ifdef IMEM_LOADER_CSUM_EN
        stim_q.push_back(x);
`endif
        run_load("vector", 2, 1'b0, 0);
        tests_run++;
        if (cap_addr_q.size() != 2 || cap_data_q[0] !== 32'h2408_0005 || cap_addr_q[0] !== 32'h0 ||
            cap_data_q[1] !== 32'h0000_000C || cap_addr_q[1] !== 32'h4) begin
            tests_failed++;
            $display("FAIL vector_const: %0d writes required 24080005@0 0000000C@4", cap_addr_q.size());
        end
    endtask

    task automatic test_zero();
        stim_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
        stim_q.push_back(8'h00);
`endif
        run_load("zero", 0, 1'b0, 0);
    endtask

    task automatic test_oversize();
        stim_q = '{8'h04, 8'h01};
        run_load("oversize", 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (err_o !== 1'b1 || cpu_hold_o !== 1'b1 || cap_addr_q.size() != 0 || byte_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL oversize_stay: err=%b hold=%b writes=%0d ready=%b required 1 1 0 0",
                     err_o, cpu_hold_o, cap_addr_q.size(), byte_ready_o);
        end
        run_load("after_err", 3, 1'b1, 0);
        // Exactly MAX_WORDS is accepted: loader keeps asking for data.
        pulse_start();
        stim_q = '{8'h04, 8'h00};
        send_bytes(0, 2, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (err_o !== 1'b0 || byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL max_words_ok: err=%b ready=%b hold=%b required 0 1 1", err_o, byte_ready_o, cpu_hold_o);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gaps();
        run_load("nogap", 8, 1'b1, 0);
        run_load("gaps", 8, 1'b0, 50);
        tests_run++;
        if (cap_addr_q.size() != 8) begin
            tests_failed++;
            $display("FAIL gaps_pulses: %0d required 8", cap_addr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        if (done_o === 1'b1 || err_o === 1'b1) pulse_start();
        cap_addr_q.delete();
        cap_data_q.delete();
        make_stream(8, 1'b1);
        model_stream();
        send_bytes(0, 2 + 4 * 3 + 2, 20);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (byte_ready_o !== 1'b0 || wr_en_imem_o !== 1'b0 || addr_imem_o !== BASE ||
            wr_instr_imem_o !== 32'h0 || cpu_hold_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_values: ready=%b wr=%b addr=%h data=%h hold=%b done=%b err=%b",
                     byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_hold_o, done_o, err_o);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (cap_addr_q.size() != 3 || cap_data_q[2] !== exp_data_q[2] || cap_addr_q[2] !== exp_addr_q[2]) begin
            tests_failed++;
            $display("FAIL midreset_writes: %0d writes required 3", cap_addr_q.size());
        end
        reset = 1'b1;
        @(negedge clk);
        run_load("after_midreset", 4, 1'b1, 0);
    endtask

    task automatic test_start_ignored();
        if (done_o === 1'b1 || err_o === 1'b1) pulse_start();
        cap_addr_q.delete();
        cap_data_q.delete();
        make_stream(2, 1'b1);
        model_stream();
        send_bytes(0, 4, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        send_bytes(4, stim_q.size(), 0);
        wait_end("start_ignored");
        check_load("start_ignored");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 5; n++) begin
            run_load("b2b", int'($urandom_range(6, 1)), 1'b1, int'($urandom_range(40, 0)));
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_bad_csum();
        stim_q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h26};
        run_load("bad_csum", 2, 1'b0, 0);
        tests_run++;
        if (err_o !== 1'b1 || cpu_hold_o !== 1'b1 || cap_addr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL bad_csum_const: err=%b hold=%b writes=%0d required 1 1 2",
                     err_o, cpu_hold_o, cap_addr_q.size());
        end
        run_load("bad_rand", 3, 1'b0, 0);
        make_stream(3, 1'b0);
        run_load("bad_rand2", 3, 1'b0, 10);
    endtask
`endif

    initial begin
        test_reset();
        test_vector();
        test_zero();
        test_oversize();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
`ifdef IMEM_LOADER_CSUM_EN
        test_bad_csum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
